// File: rtl/dcache_pkg.sv
// Shared types for the data-cache stage.
// Widths, address-field slices, request bundle and FSM states.
package dcache_pkg;

  localparam int ADDR_WIDTH    = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int PC_WIDTH      = 32;
  localparam int LINE_WIDTH    = 128;
  localparam int NUM_LINES     = 4;
  localparam int RF_ADDR_WIDTH = 5;

  localparam int TAG_LSB = 6;
  localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;
  localparam int IDX_LSB = 4;
  localparam int IDX_W   = 2;
  localparam int WRD_LSB = 2;
  localparam int WRD_W   = 2;
  localparam int BYT_W   = 2;

  typedef enum logic {
    Byte = 1'b0,
    Word = 1'b1
  } size_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  is_store;
    size_t                 size;
  } dcache_request_t;

  typedef enum logic [1:0] {
    IDLE,
    EVICT,
    FILL,
    REPLAY
  } dc_state_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0]      pc;
    dcache_request_t          info;
    logic [RF_ADDR_WIDTH-1:0] dst;
  } hold_t;

endpackage

// File: rtl/dcache_if.sv
// ALU/WB/memory bundle of the data-cache stage.
// slave = cache stage, master = ALU stage plus memory model.
interface dcache_if;
  import dcache_pkg::*;

  logic                     req_dcache_valid;
  logic [PC_WIDTH-1:0]      req_dcache_pc;
  dcache_request_t          req_dcache_info;
  logic                     req_m_type_instr;
  logic                     req_r_type_instr;
  logic [RF_ADDR_WIDTH-1:0] req_dst_reg;
  logic                     dcache_busy;
  logic [DATA_WIDTH-1:0]    cache_data_bypass;
  logic                     req_wb_valid;
  logic [PC_WIDTH-1:0]      req_wb_pc;
  logic [DATA_WIDTH-1:0]    req_wb_data;
  logic [RF_ADDR_WIDTH-1:0] req_wb_dst_reg;
  logic                     req_wb_write_rf;
  logic                     xcpt_dcache;
  logic                     req_mem_valid;
  logic [ADDR_WIDTH-1:0]    req_mem_addr;
  logic                     req_mem_is_store;
  logic [LINE_WIDTH-1:0]    req_mem_data;
  logic                     rsp_mem_valid;
  logic [LINE_WIDTH-1:0]    rsp_mem_data;

  modport master (
    output req_dcache_valid, req_dcache_pc,
    output req_dcache_info, req_m_type_instr,
    output req_r_type_instr, req_dst_reg,
    output rsp_mem_valid, rsp_mem_data,
    input  dcache_busy, cache_data_bypass,
    input  req_wb_valid, req_wb_pc, req_wb_data,
    input  req_wb_dst_reg, req_wb_write_rf,
    input  xcpt_dcache, req_mem_valid,
    input  req_mem_addr, req_mem_is_store,
    input  req_mem_data
  );

  modport slave (
    input  req_dcache_valid, req_dcache_pc,
    input  req_dcache_info, req_m_type_instr,
    input  req_r_type_instr, req_dst_reg,
    input  rsp_mem_valid, rsp_mem_data,
    output dcache_busy, cache_data_bypass,
    output req_wb_valid, req_wb_pc, req_wb_data,
    output req_wb_dst_reg, req_wb_write_rf,
    output xcpt_dcache, req_mem_valid,
    output req_mem_addr, req_mem_is_store,
    output req_mem_data
  );

endinterface

// File: rtl/dcache_data_array.sv
// Tag/valid/dirty/line storage: comb read, sync fill or
// byte-masked word store, async clear of valid and dirty.
module dcache_data_array
  import dcache_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [IDX_W-1:0]      i_rd_idx,
  output logic                  o_rd_valid,
  output logic                  o_rd_dirty,
  output logic [TAG_W-1:0]      o_rd_tag,
  output logic [LINE_WIDTH-1:0] o_rd_line,
  input  logic [IDX_W-1:0]      i_wr_idx,
  input  logic                  i_fill_en,
  input  logic [TAG_W-1:0]      i_fill_tag,
  input  logic [LINE_WIDTH-1:0] i_fill_line,
  input  logic                  i_st_en,
  input  logic [WRD_W-1:0]      i_st_word,
  input  logic [3:0]            i_st_be,
  input  logic [DATA_WIDTH-1:0] i_st_data
);

  logic [NUM_LINES-1:0]  r_valid;
  logic [NUM_LINES-1:0]  r_dirty;
  logic [TAG_W-1:0]      r_tag  [NUM_LINES];
  logic [LINE_WIDTH-1:0] r_line [NUM_LINES];
  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_new;

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_dirty = r_dirty[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_line  = r_line[i_rd_idx];

  always_comb begin
    w_old = r_line[i_wr_idx][{i_st_word, 5'b0} +: DATA_WIDTH];
    w_new = w_old;
    for (int b = 0; b < 4; b++) begin
      if (i_st_be[b]) w_new[b*8 +: 8] = i_st_data[b*8 +: 8];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_en) begin
      r_valid[i_wr_idx] <= 1'b1;
      r_dirty[i_wr_idx] <= 1'b0;
    end else if (i_st_en) begin
      r_dirty[i_wr_idx] <= 1'b1;
    end
  end

  // Payload storage is not reset; valid bits guard it.
  always_ff @(posedge clock) begin
    if (i_fill_en) begin
      r_tag[i_wr_idx]  <= i_fill_tag;
      r_line[i_wr_idx] <= i_fill_line;
    end else if (i_st_en) begin
      r_line[i_wr_idx][{i_st_word, 5'b0} +: DATA_WIDTH] <= w_new;
    end
  end

endmodule

// File: rtl/dcache_top.sv
// Data-cache stage: 4-line direct-mapped write-back cache,
// blocking miss FSM, WB/bypass flops. Ports: clock, reset, bus.
module dcache_top
  import dcache_pkg::*;
(
  input logic     clock,
  input logic     reset,
  dcache_if.slave bus
);

  dc_state_t r_state;
  dc_state_t w_next;
  hold_t     r_hold;
  hold_t     w_cur;

  logic                     w_idle;
  logic                     w_cur_m;
  logic                     w_cur_r;
  logic                     w_go;
  logic                     w_hit;
  logic                     w_misal;
  logic                     w_miss;
  logic [IDX_W-1:0]         w_idx;
  logic [TAG_W-1:0]         w_tag;
  logic [WRD_W-1:0]         w_wsel;
  logic [BYT_W-1:0]         w_bsel;
  logic                     w_rd_valid;
  logic                     w_rd_dirty;
  logic [TAG_W-1:0]         w_rd_tag;
  logic [LINE_WIDTH-1:0]    w_rd_line;
  logic [DATA_WIDTH-1:0]    w_word;
  logic [7:0]               w_byte;

  logic                     w_retire;
  logic [DATA_WIDTH-1:0]    w_wb_data;
  logic                     w_wb_wrf;
  logic                     w_wb_xcpt;
  logic                     w_fill_en;
  logic                     w_st_en;
  logic [3:0]               w_st_be;
  logic [DATA_WIDTH-1:0]    w_st_data;
  logic                     w_mem_valid;
  logic                     w_mem_store;
  logic [ADDR_WIDTH-1:0]    w_mem_addr;
  logic [LINE_WIDTH-1:0]    w_mem_data;

  logic                     r_wb_valid;
  logic [PC_WIDTH-1:0]      r_wb_pc;
  logic [DATA_WIDTH-1:0]    r_wb_data;
  logic [RF_ADDR_WIDTH-1:0] r_wb_dst;
  logic                     r_wb_wrf;
  logic                     r_wb_xcpt;

  // Outside IDLE the stage works on the held miss request.
  assign w_idle  = (r_state == IDLE);
  assign w_cur   = w_idle ? {bus.req_dcache_pc,
                             bus.req_dcache_info,
                             bus.req_dst_reg} : r_hold;
  assign w_cur_m = w_idle ? bus.req_m_type_instr : 1'b1;
  assign w_cur_r = w_idle & bus.req_r_type_instr;
  assign w_go    = (w_idle & bus.req_dcache_valid)
                 | (r_state == REPLAY);

  assign w_tag  = w_cur.info.addr[TAG_LSB +: TAG_W];
  assign w_idx  = w_cur.info.addr[IDX_LSB +: IDX_W];
  assign w_wsel = w_cur.info.addr[WRD_LSB +: WRD_W];
  assign w_bsel = w_cur.info.addr[BYT_W-1:0];

  dcache_data_array u_array (
    .clock       (clock),
    .reset       (reset),
    .i_rd_idx    (w_idx),
    .o_rd_valid  (w_rd_valid),
    .o_rd_dirty  (w_rd_dirty),
    .o_rd_tag    (w_rd_tag),
    .o_rd_line   (w_rd_line),
    .i_wr_idx    (w_idx),
    .i_fill_en   (w_fill_en),
    .i_fill_tag  (w_tag),
    .i_fill_line (bus.rsp_mem_data),
    .i_st_en     (w_st_en),
    .i_st_word   (w_wsel),
    .i_st_be     (w_st_be),
    .i_st_data   (w_st_data)
  );

  assign w_word  = w_rd_line[{w_wsel, 5'b0} +: DATA_WIDTH];
  assign w_byte  = w_word[{w_bsel, 3'b0} +: 8];
  assign w_hit   = w_rd_valid & (w_rd_tag == w_tag);
  assign w_misal = (w_cur.info.size == Word) & (w_bsel != '0);
  assign w_miss  = w_idle & bus.req_dcache_valid & w_cur_m
                 & ~w_misal & ~w_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_miss)
          w_next = (w_rd_valid & w_rd_dirty) ? EVICT : FILL;
      end
      EVICT:   if (bus.rsp_mem_valid) w_next = FILL;
      FILL:    if (bus.rsp_mem_valid) w_next = REPLAY;
      REPLAY:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_retire    = 1'b0;
    w_wb_data   = w_cur.info.data;
    w_wb_wrf    = 1'b0;
    w_wb_xcpt   = 1'b0;
    w_fill_en   = 1'b0;
    w_st_en     = 1'b0;
    w_st_be     = 4'h0;
    w_st_data   = '0;
    w_mem_valid = 1'b0;
    w_mem_store = 1'b0;
    w_mem_addr  = '0;
    w_mem_data  = '0;
    unique case (r_state)
      IDLE, REPLAY: begin
        if (w_go) begin
          if (!w_cur_m) begin
            w_retire = 1'b1;
            w_wb_wrf = w_cur_r;
          end else if (w_misal) begin
            w_retire  = 1'b1;
            w_wb_xcpt = 1'b1;
          end else if (w_hit) begin
            w_retire = 1'b1;
            if (w_cur.info.is_store) begin
              w_st_en = 1'b1;
              if (w_cur.info.size == Word) begin
                w_st_be   = 4'hF;
                w_st_data = w_cur.info.data;
              end else begin
                w_st_be   = 4'h1 << w_bsel;
                w_st_data = {4{w_cur.info.data[7:0]}};
              end
            end else begin
              w_wb_wrf  = 1'b1;
              w_wb_data = (w_cur.info.size == Word) ? w_word
                          : {24'h0, w_byte};
            end
          end
        end
      end
      EVICT: begin
        w_mem_valid = 1'b1;
        w_mem_store = 1'b1;
        w_mem_addr  = {w_rd_tag, w_idx, 4'h0};
        w_mem_data  = w_rd_line;
      end
      FILL: begin
        w_mem_valid = 1'b1;
        w_mem_addr  = {w_tag, w_idx, 4'h0};
        w_fill_en   = bus.rsp_mem_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_hold <= '0;
    else if (w_miss) r_hold <= w_cur;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_wb_pc    <= '0;
      r_wb_data  <= '0;
      r_wb_dst   <= '0;
      r_wb_wrf   <= 1'b0;
      r_wb_xcpt  <= 1'b0;
    end else begin
      r_wb_valid <= w_retire;
      if (w_retire) begin
        r_wb_pc   <= w_cur.pc;
        r_wb_data <= w_wb_data;
        r_wb_dst  <= w_cur.dst;
        r_wb_wrf  <= w_wb_wrf;
        r_wb_xcpt <= w_wb_xcpt;
      end
    end
  end

  // Busy is combinational so a miss stalls the very next issue.
  assign bus.dcache_busy       = ~w_idle | w_miss;
  assign bus.req_wb_valid      = r_wb_valid;
  assign bus.req_wb_pc         = r_wb_pc;
  assign bus.req_wb_data       = r_wb_data;
  assign bus.cache_data_bypass = r_wb_data;
  assign bus.req_wb_dst_reg    = r_wb_dst;
  assign bus.req_wb_write_rf   = r_wb_wrf;
  assign bus.xcpt_dcache       = r_wb_xcpt & r_wb_valid;
  assign bus.req_mem_valid     = w_mem_valid;
  assign bus.req_mem_is_store  = w_mem_store;
  assign bus.req_mem_addr      = w_mem_addr;
  assign bus.req_mem_data      = w_mem_data;

  a_no_req_when_busy: assert property (
    @(posedge clock) disable iff (reset)
    !(bus.req_dcache_valid && r_state != IDLE)
  );

endmodule
